// File: rtl/regs_pkg.sv
// Shared widths, constants, debug FSM encoding and slice helpers for the
// multi-port register file.
package regs_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  localparam int                      ZERO_REG  = 0;
  localparam logic [DEF_DATA_W-1:0]   ZERO_WORD = {DEF_DATA_W{1'b0}};

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_WAIT = 2'd1,
    DBG_ACK  = 2'd2
  } dbg_state_e;

  // Low bit of port idx inside a flattened vector of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regs_dbg_ctrl.sv
// Debug access controller: handshake FSM, starvation wait counter, captured
// read data and the core stall request.
module regs_dbg_ctrl
  import regs_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DBG_WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              core_wr_any_i,
  input  logic [DATA_W-1:0] dbg_rd_data_i,
  output logic              dbg_wr_en_o,
  output logic [ADDR_W-1:0] dbg_wr_addr_o,
  output logic [DATA_W-1:0] dbg_wr_data_o,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              core_stall_o
);

  localparam int CNT_W = $clog2(DBG_WAIT_MAX + 1);

  dbg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              stall_q, stall_d;

  // Request fields are held stable until ack, so they feed the storage directly.
  assign dbg_wr_addr_o = dbg_addr_i;
  assign dbg_wr_data_o = dbg_wdata_i;
  assign dbg_ack_o     = ack_q;
  assign dbg_rdata_o   = rdata_q;
  assign core_stall_o  = stall_q;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DBG_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
    end
  end

  // Next state; a debug write only commits in a cycle with no core write.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    dbg_wr_en_o = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (!dbg_req_i) begin
          state_d = DBG_IDLE;
        end else if (!dbg_we_i) begin
          rdata_d = dbg_rd_data_i;
          state_d = DBG_ACK;
        end else if (!core_wr_any_i) begin
          dbg_wr_en_o = 1'b1;
          state_d     = DBG_ACK;
        end else begin
          state_d = DBG_WAIT;
          cnt_d   = CNT_W'(1'b1);
        end
      end
      DBG_WAIT: begin
        if (!core_wr_any_i) begin
          dbg_wr_en_o = 1'b1;
          state_d     = DBG_ACK;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          cnt_d = (cnt_q >= CNT_W'(DBG_WAIT_MAX)) ? cnt_q : cnt_q + CNT_W'(1'b1);
        end
      end
      DBG_ACK: begin
        state_d = DBG_IDLE;
      end
      default: begin
        state_d = DBG_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    ack_d   = (state_d == DBG_ACK);
    stall_d = (state_d == DBG_WAIT) && (cnt_d >= CNT_W'(DBG_WAIT_MAX));
  end

endmodule

// File: rtl/regs_mp.sv
// Multi-port register file with write bypass, busy scoreboard and a
// handshaked debug port; entry 0 reads as zero.
module regs_mp
  import regs_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 1,
  parameter int DBG_WAIT_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  input  logic                     flush_i,
  input  logic                     dbg_req_i,
  input  logic                     dbg_we_i,
  input  logic [ADDR_W-1:0]        dbg_addr_i,
  input  logic [DATA_W-1:0]        dbg_wdata_i,
  output logic                     dbg_ack_o,
  output logic [DATA_W-1:0]        dbg_rdata_o,
  output logic                     core_stall_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic              dbg_wr_en_s;
  logic [ADDR_W-1:0] dbg_wr_addr_s;
  logic [DATA_W-1:0] dbg_wr_data_s;
  logic [DATA_W-1:0] dbg_rd_data_s;
  logic              core_wr_any_s;

  assign core_wr_any_s = |wr_en_i;

  function automatic logic write_hit(input logic [ADDR_W-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      hit = hit | (wr_en_i[k] && (wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W] == addr));
    end
    return hit;
  endfunction

  // Later ports overwrite earlier ones, so the highest matching port wins.
  function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = mem_q[addr];
    for (int k = 0; k < NUM_WR; k++) begin
      val = (wr_en_i[k] && (wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W] == addr))
            ? wr_data_i[slice_lo(k, DATA_W) +: DATA_W] : val;
    end
    return (addr == ADDR_W'(ZERO_REG)) ? DATA_W'(ZERO_WORD) : val;
  endfunction

  // Combinational read ports and debug read source.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data_o[slice_lo(p, DATA_W) +: DATA_W] =
        bypass_read(rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W]);
      rd_busy_o[p] = busy_q[rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W]]
                   & ~write_hit(rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W])
                   & (rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W] != ADDR_W'(ZERO_REG));
    end
    dbg_rd_data_s = bypass_read(dbg_addr_i);
  end

  // Storage next state; a debug write never coincides with a core write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    mem_d[dbg_wr_addr_s] = dbg_wr_en_s ? dbg_wr_data_s : mem_d[dbg_wr_addr_s];
    for (int k = 0; k < NUM_WR; k++) begin
      mem_d[wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W]] =
        wr_en_i[k] ? wr_data_i[slice_lo(k, DATA_W) +: DATA_W]
                   : mem_d[wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W]];
    end
    mem_d[ZERO_REG] = DATA_W'(ZERO_WORD);
  end

  // Scoreboard: writes clear, allocation sets over them, flush clears everything.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      busy_d[wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W]] =
        wr_en_i[k] ? 1'b0 : busy_d[wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W]];
    end
    busy_d[alloc_addr_i] = alloc_en_i ? 1'b1 : busy_d[alloc_addr_i];
    busy_d[ZERO_REG]     = 1'b0;
    busy_d               = flush_i ? {DEPTH{1'b0}} : busy_d;
  end

  // Storage and scoreboard registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(ZERO_WORD);
      end
      busy_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q <= busy_d;
    end
  end

  regs_dbg_ctrl #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .DBG_WAIT_MAX (DBG_WAIT_MAX)
  ) u_dbg_ctrl (
    .clk           (clk),
    .rst           (rst),
    .dbg_req_i     (dbg_req_i),
    .dbg_we_i      (dbg_we_i),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_wdata_i   (dbg_wdata_i),
    .core_wr_any_i (core_wr_any_s),
    .dbg_rd_data_i (dbg_rd_data_s),
    .dbg_wr_en_o   (dbg_wr_en_s),
    .dbg_wr_addr_o (dbg_wr_addr_s),
    .dbg_wr_data_o (dbg_wr_data_s),
    .dbg_ack_o     (dbg_ack_o),
    .dbg_rdata_o   (dbg_rdata_o),
    .core_stall_o  (core_stall_o)
  );

endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp with a behavioural reference model compared on
// every falling edge plus hand-computed literal expectations.
module tb_regs_mp;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int WMAX   = 8;
  localparam int DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     alloc_en;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic                     dbg_req;
  logic                     dbg_we;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_wdata;
  logic                     dbg_ack;
  logic [DATA_W-1:0]        dbg_rdata;
  logic                     core_stall;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  regs_mp #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DBG_WAIT_MAX(WMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .flush_i(flush),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata), .core_stall_o(core_stall)
  );

  // Reference model state.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_busy [DEPTH];
  bit                m_ack;
  logic [DATA_W-1:0] m_rdata;
  int                m_blocked;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit written(input int a);
    bit h = 1'b0;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k] && int'(wr_addr[k*ADDR_W +: ADDR_W]) == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input int a);
    logic [DATA_W-1:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    for (int k = 0; k < NUM_WR; k++)
      if (wr_en[k] && int'(wr_addr[k*ADDR_W +: ADDR_W]) == a) v = wr_data[k*DATA_W +: DATA_W];
    return v;
  endfunction

  // Model update: m_blocked counts edges a pending debug write lost to the core.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= 32'h0;
        m_busy[i] <= 1'b0;
      end
      m_ack     <= 1'b0;
      m_rdata   <= 32'h0;
      m_blocked <= 0;
    end else begin
      if (m_ack) begin
        m_ack <= 1'b0;
      end else if (dbg_req) begin
        if (!dbg_we) begin
          m_rdata <= exp_read(int'(dbg_addr));
          m_ack   <= 1'b1;
        end else if (wr_en == 2'b00) begin
          if (dbg_addr != 5'd0) m_mem[dbg_addr] <= dbg_wdata;
          m_ack     <= 1'b1;
          m_blocked <= 0;
        end else begin
          m_blocked <= m_blocked + 1;
        end
      end
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != 5'd0) begin
          m_mem[wr_addr[k*ADDR_W +: ADDR_W]]  <= wr_data[k*DATA_W +: DATA_W];
          m_busy[wr_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (alloc_en && alloc_addr != 5'd0) m_busy[alloc_addr] <= 1'b1;
      if (flush) for (int i = 0; i < DEPTH; i++) m_busy[i] <= 1'b0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < NUM_RD; p++) begin
        int a;
        a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
        chk("model_rd_data", rd_data[p*DATA_W +: DATA_W], exp_read(a));
        chk("model_rd_busy", {31'h0, rd_busy[p]}, {31'h0, (a != 0) && m_busy[a] && !written(a)});
      end
      chk("model_dbg_ack", {31'h0, dbg_ack}, {31'h0, m_ack});
      chk("model_dbg_rdata", dbg_rdata, m_rdata);
      chk("model_core_stall", {31'h0, core_stall}, {31'h0, m_blocked >= WMAX});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input logic en, input int a, input logic [DATA_W-1:0] d);
    wr_en[k] = en;
    wr_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  initial begin
    rst = 1'b0; wr_en = 2'b00; wr_addr = 10'h0; wr_data = 64'h0; rd_addr = 10'h0;
    alloc_en = 1'b0; alloc_addr = 5'd0; flush = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    chk("rst_ack", {31'h0, dbg_ack}, 32'h0);
    chk("rst_stall", {31'h0, core_stall}, 32'h0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // All registers read zero and idle after reset.
    for (int i = 1; i < DEPTH; i++) begin
      rd(0, i); rd(1, DEPTH - i);
      #1;
      chk("reset_read", rd_data[31:0], 32'h0);
      chk("reset_busy", {30'h0, rd_busy}, 32'h0);
      tick();
    end

    // Two ports hit x5 together: port 1 wins, in bypass and in storage.
    wr(0, 1'b1, 5, 32'h11); wr(1, 1'b1, 5, 32'h22); rd(0, 5);
    #1; chk("dual_bypass", rd_data[31:0], 32'h22);
    tick(); wr_en = 2'b00;
    #1; chk("dual_store", rd_data[31:0], 32'h22);

    // x0 ignores writes.
    wr(0, 1'b1, 0, 32'hFFFF_FFFF); rd(0, 0);
    #1; chk("zero_bypass", rd_data[31:0], 32'h0);
    tick(); wr_en = 2'b00;
    #1; chk("zero_store", rd_data[31:0], 32'h0);

    // Scoreboard.
    alloc_en = 1'b1; alloc_addr = 5'd7; rd(1, 7);
    #1; chk("alloc_not_yet", {31'h0, rd_busy[1]}, 32'h0);
    tick(); alloc_en = 1'b0;
    #1; chk("alloc_busy", {31'h0, rd_busy[1]}, 32'h1);
    wr(0, 1'b1, 7, 32'h7);
    #1; chk("wb_busy_clear", {31'h0, rd_busy[1]}, 32'h0);
    chk("wb_bypass", rd_data[63:32], 32'h7);
    tick(); wr_en = 2'b00;
    #1; chk("wb_busy_after", {31'h0, rd_busy[1]}, 32'h0);
    alloc_en = 1'b1; alloc_addr = 5'd7; wr(0, 1'b1, 7, 32'h8);
    tick(); alloc_en = 1'b0; wr_en = 2'b00;
    #1; chk("alloc_wins", {31'h0, rd_busy[1]}, 32'h1);
    alloc_en = 1'b1; alloc_addr = 5'd9; rd(0, 9);
    tick();
    #1; chk("alloc9_busy", {31'h0, rd_busy[0]}, 32'h1);
    flush = 1'b1;
    tick(); flush = 1'b0; alloc_en = 1'b0;
    #1; chk("flush_x9", {31'h0, rd_busy[0]}, 32'h0);
    chk("flush_x7", {31'h0, rd_busy[1]}, 32'h0);

    // Debug read of x3.
    wr(0, 1'b1, 3, 32'hABCD);
    tick(); wr_en = 2'b00;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    #1; chk("dbg_rd_no_ack", {31'h0, dbg_ack}, 32'h0);
    tick(); chk("dbg_rd_ack", {31'h0, dbg_ack}, 32'h1);
    chk("dbg_rd_data", dbg_rdata, 32'hABCD);
    dbg_req = 1'b0;
    tick(); chk("dbg_rd_ack_drop", {31'h0, dbg_ack}, 32'h0);
    chk("dbg_rd_hold", dbg_rdata, 32'hABCD);

    // Request held through ACK: back-to-back reads of x7 every 2 cycles.
    dbg_req = 1'b1; dbg_addr = 5'd7;
    tick(); chk("b2b_ack1", {31'h0, dbg_ack}, 32'h1); chk("b2b_data", dbg_rdata, 32'h8);
    tick(); chk("b2b_gap", {31'h0, dbg_ack}, 32'h0);
    tick(); chk("b2b_ack2", {31'h0, dbg_ack}, 32'h1);
    dbg_req = 1'b0;
    tick();

    // Starvation: core writes every cycle while a debug write to x4 waits.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h55;
    wr(0, 1'b1, 10, 32'h100);
    for (int n = 1; n <= WMAX + 3; n++) begin
      tick();
      wr(0, 1'b1, 10, 32'h100 + n);
      chk("stall_level", {31'h0, core_stall}, {31'h0, n >= WMAX});
      chk("stall_no_ack", {31'h0, dbg_ack}, 32'h0);
    end
    wr_en = 2'b00;
    #1; chk("stall_held", {31'h0, core_stall}, 32'h1);
    tick(); chk("stall_drop", {31'h0, core_stall}, 32'h0);
    chk("dbg_wr_ack", {31'h0, dbg_ack}, 32'h1);
    dbg_req = 1'b0; rd(0, 4);
    #1; chk("dbg_wr_store", rd_data[31:0], 32'h55);
    tick();

    // Debug write to x0 is acked with no effect.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hDEAD;
    tick(); chk("dbg_x0_ack", {31'h0, dbg_ack}, 32'h1);
    dbg_req = 1'b0; rd(0, 0);
    tick(); chk("dbg_x0_read", rd_data[31:0], 32'h0);

    // Reset while waiting aborts the write.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h77;
    wr(0, 1'b1, 11, 32'h1);
    repeat (3) tick();
    rst = 1'b0;
    #1; chk("abort_ack", {31'h0, dbg_ack}, 32'h0);
    chk("abort_stall", {31'h0, core_stall}, 32'h0);
    dbg_req = 1'b0; wr_en = 2'b00;
    tick(); rst = 1'b1;
    tick(); rd(0, 12); rd(1, 3);
    #1; chk("abort_no_write", rd_data[31:0], 32'h0);
    chk("reset_clears", rd_data[63:32], 32'h0);
    chk("abort_no_ack", {31'h0, dbg_ack}, 32'h0);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the single-write/dual-read GPR block.
- Adds configurable read and write port counts, per-register busy scoreboard for out-of-order writeback, full reset clear, and a handshaked debug (JTAG) access port with its own FSM and starvation guard.
- Sits between decode (reads, allocation), the writeback stages (writes) and the debug module.

Parameters:
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries, and entry 0 is hardwired to zero.
- DATA_W, 32, register data width.
- NUM_RD, 2, number of read ports (1..8).
- NUM_WR, 1, number of write ports (1..4).
- DBG_WAIT_MAX, 8, debug-write wait cycles before core_stall_o is raised (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses; port k occupies slice k.
- wr_data_i  in  NUM_WR*DATA_W  write data.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses.
- rd_data_o  out  NUM_RD*DATA_W  read data, combinational.
- rd_busy_o  out  NUM_RD  1 = register has a pending producer.
- alloc_en_i  in  1  mark alloc_addr_i busy (instruction issue).
- alloc_addr_i  in  ADDR_W  destination being allocated.
- flush_i  in  1  clear all busy bits (pipeline flush).
- dbg_req_i  in  1  debug request; held with its fields stable until dbg_ack_o.
- dbg_we_i  in  1  1 = write, 0 = read.
- dbg_addr_i  in  ADDR_W  debug address.
- dbg_wdata_i  in  DATA_W  debug write data.
- dbg_ack_o  out  1  single-cycle completion pulse.
- dbg_rdata_o  out  DATA_W  debug read data, valid while dbg_ack_o=1 and held until the next ack.
- core_stall_o  out  1  asks the pipeline to idle its write ports.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries are 0 and all busy bits are 0.
  - FSM goes to IDLE, wait counter is 0.
  - dbg_ack_o=0, dbg_rdata_o=0, core_stall_o=0.
- Writes: commit at the clock edge.
  - Address 0 is never written.
  - If several enabled ports target the same address, the highest port index wins.
- Read path, per port, combinational:
  - Address 0 returns 0.
  - Otherwise the port returns the highest-index enabled write port whose address matches (bypass).
  - Otherwise it returns the stored value.
- rd_busy_o = busy[addr] AND no enabled write to addr this cycle. Address 0 always reports 0.
- Scoreboard update at each edge, in priority order:
  1. flush_i clears every bit, including a same-cycle allocation.
  2. Otherwise, alloc_en_i sets busy[alloc_addr_i]; allocation of address 0 is ignored.
  3. Any enabled core write clears busy for its address.
  - Alloc and write to the same address in one cycle: set wins, because there is a new producer.
  - Debug writes never change busy.
- Debug FSM states: IDLE, WAIT, ACK.
  - IDLE, dbg_req_i=1, read: at the edge, capture bypassed read data for dbg_addr_i into dbg_rdata_o; go to ACK.
  - IDLE, dbg_req_i=1, write, all wr_en_i=0: commit the write at this edge; go to ACK.
  - IDLE, dbg_req_i=1, write, any wr_en_i=1: go to WAIT with counter=1.
  - WAIT: the same commit condition is checked each cycle. On success go to ACK and clear the counter; otherwise increment the counter, saturating at DBG_WAIT_MAX.
  - core_stall_o = 1 when the state is WAIT and counter >= DBG_WAIT_MAX. It is registered and drops at the edge the write commits.
  - ACK: dbg_ack_o=1 for exactly one cycle, then IDLE. dbg_req_i is ignored during ACK, so back-to-back requests cost 2 cycles minimum.
  - A debug write to address 0 is acked with no effect.
- Latency:
  - Core write: visible in storage 1 cycle after the edge; visible through the bypass in the same cycle.
  - Debug access: ack in the cycle after the commit edge.
- Reset during WAIT or ACK aborts the access with no write and no ack.
- The core has priority over debug on any conflict. A debug write never drops or delays a core write.

Decomposition:
- regs_pkg holds:
  - default widths;
  - ZERO_REG address and ZERO_WORD constants;
  - debug FSM state encoding (IDLE=2'd0, WAIT=2'd1, ACK=2'd2);
  - slice helper functions for the flattened port vectors.
- Sub-module regs_dbg_ctrl holds the FSM, wait counter, dbg_rdata register and core_stall_o. It outputs a debug write strobe and address/data to the storage core.
- Storage, bypass and scoreboard stay in regs_mp.

Test Plan:
- Reset then read: release reset, read x1..x31 on all ports -> all 0, rd_busy_o=0.
- Dual write, same address (NUM_WR=2): port0 writes x5=0x11 and port1 writes x5=0x22 in the same cycle.
  - During that cycle, rd_data for x5 = 0x22.
  - Next cycle, stored value = 0x22.
- Write to zero register: write x0=0xFFFFFFFF -> reads of x0 return 0.
- Scoreboard:
  - alloc x7 -> rd_busy=1 next cycle.
  - Write x7=0x7 -> rd_busy=0 in the same cycle and data=0x7.
  - Alloc and write x7 together -> busy stays 1.
  - flush_i together with alloc x9 -> all busy bits 0.
- Debug read: x3=0xABCD stored, dbg read x3 -> dbg_ack_o high 1 cycle later, dbg_rdata_o=0xABCD.
- Debug write starvation: hold wr_en_i=1 continuously and issue a debug write x4=0x55.
  - core_stall_o rises after 8 wait cycles.
  - Drop wr_en_i -> write commits, core_stall_o=0, ack the next cycle, x4 reads 0x55.
